// File: rtl/jt51_lfo_pkg.sv
// Shared constants for the jt51 LFO register front end: register map, waveforms, busy timing.
package jt51_lfo_pkg;

   localparam logic [7:0] REG_TEST = 8'h01;
   localparam logic [7:0] REG_LFRQ = 8'h18;
   localparam logic [7:0] REG_PAMD = 8'h19;
   localparam logic [7:0] REG_CTW  = 8'h1B;

   typedef enum logic [1:0] {
      SAWTOOTH = 2'd0,
      SQUARE   = 2'd1,
      TRIANG   = 2'd2,
      NOISE    = 2'd3
   } lfo_wave_e;

   localparam int BUSY_CYC_DEF = 32;

endpackage

// File: rtl/jt51_cyc_cnt.sv
// Free-running 5-bit slot counter advanced once per cen; shared by the LFO and operator pipeline.
module jt51_cyc_cnt #(
   parameter logic [4:0] RST_VAL = 5'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   output logic [4:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= RST_VAL;
      end else if (cen) begin
         cnt <= cnt + 5'd1;
      end
   end

endmodule

// File: rtl/jt51_lfo_regs.sv
// CPU bus front end for the jt51 LFO: latches writes, commits them at slot 31, drives LFO config.
// Optional readback port dout is enabled by defining JT51_LFO_RDBACK_EN.
module jt51_lfo_regs
   import jt51_lfo_pkg::*;
#(
   parameter int         BUSY_CYC = BUSY_CYC_DEF,
   parameter logic [4:0] CYC_RST  = 5'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   input  logic       cs_n,
   input  logic       wr_n,
   input  logic       a0,
   input  logic [7:0] din,
   output logic       busy,
   output logic [4:0] cycles,
   output logic [7:0] lfo_freq,
   output logic [6:0] lfo_amd,
   output logic [6:0] lfo_pmd,
   output logic [1:0] lfo_w,
   output logic [1:0] ct,
   output logic [7:0] test,
   output logic       lfo_up
`ifdef JT51_LFO_RDBACK_EN
   ,
   output logic [7:0] dout
`endif
);

   localparam logic [5:0] BUSY_LD = 6'(BUSY_CYC);

   logic       r_busN;
   logic [7:0] r_addr;
   logic [7:0] r_pAddr;
   logic [7:0] r_pData;
   logic       r_pending;
   logic       r_busy;
   logic [5:0] r_busyCnt;
   logic       r_upReq;
   logic       r_lfoUp;
   logic       w_strobe;
   logic       w_addrWr;
   logic       w_dataWr;
   logic       w_commit;
   logic [4:0] w_cycles;

   jt51_cyc_cnt #(.RST_VAL(CYC_RST)) u_cyc (
      .clk (clk),
      .rst (rst),
      .cen (cen),
      .cnt (w_cycles)
   );

   assign cycles = w_cycles;
   assign busy   = r_busy;
   assign lfo_up = r_lfoUp;

   // One strobe per low phase of the combined bus select.
   assign w_strobe = r_busN & ~(cs_n | wr_n);
   assign w_addrWr = w_strobe & ~a0;
   assign w_dataWr = w_strobe & a0 & ~r_busy;
   assign w_commit = cen & r_pending & (w_cycles == 5'd31);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busN <= 1'b1;
         r_addr <= 8'd0;
      end else begin
         r_busN <= cs_n | wr_n;
         if (w_addrWr) r_addr <= din;
      end
   end

   // Busy runs through the commit wait and then BUSY_CYC more cen ticks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pAddr   <= 8'd0;
         r_pData   <= 8'd0;
         r_pending <= 1'b0;
         r_busy    <= 1'b0;
         r_busyCnt <= 6'd0;
         r_upReq   <= 1'b0;
         r_lfoUp   <= 1'b0;
      end else begin
         r_upReq <= 1'b0;
         r_lfoUp <= r_upReq;
         if (w_dataWr) begin
            r_pAddr   <= r_addr;
            r_pData   <= din;
            r_pending <= 1'b1;
            r_busy    <= 1'b1;
            r_busyCnt <= BUSY_LD;
         end else if (w_commit) begin
            r_pending <= 1'b0;
            r_upReq   <= (r_pAddr == REG_LFRQ) | ((r_pAddr == REG_TEST) & r_pData[1]);
         end else if (cen && r_busy && !r_pending) begin
            r_busyCnt <= r_busyCnt - 6'd1;
            if (r_busyCnt == 6'd1) r_busy <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfo_freq <= 8'd0;
         lfo_amd  <= 7'd0;
         lfo_pmd  <= 7'd0;
         lfo_w    <= 2'd0;
         ct       <= 2'd0;
         test     <= 8'd0;
      end else if (w_commit) begin
         case (r_pAddr)
            REG_TEST: test     <= r_pData;
            REG_LFRQ: lfo_freq <= r_pData;
            REG_PAMD: begin
               if (r_pData[7]) lfo_pmd <= r_pData[6:0];
               else            lfo_amd <= r_pData[6:0];
            end
            REG_CTW: begin
               lfo_w <= r_pData[1:0];
               ct    <= r_pData[7:6];
            end
            default: ;
         endcase
      end
   end

`ifdef JT51_LFO_RDBACK_EN
   logic       r_pmdSel;
   logic [7:0] w_rdData;

   // Remembers which half of 0x19 was written last so readback returns that one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pmdSel <= 1'b0;
      end else if (w_commit && (r_pAddr == REG_PAMD)) begin
         r_pmdSel <= r_pData[7];
      end
   end

   always_comb begin
      w_rdData = 8'd0;
      case (r_addr)
         REG_TEST: w_rdData = test;
         REG_LFRQ: w_rdData = lfo_freq;
         REG_PAMD: w_rdData = r_pmdSel ? {1'b1, lfo_pmd} : {1'b0, lfo_amd};
         REG_CTW:  w_rdData = {ct, 4'd0, lfo_w};
         default:  w_rdData = 8'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout <= 8'd0;
      end else if (!cs_n && wr_n) begin
         dout <= a0 ? w_rdData : {r_busy, 7'd0};
      end else begin
         dout <= 8'd0;
      end
   end
`endif

endmodule

// File: tb/tb_jt51_lfo_regs.sv
// Scoreboard bench for jt51_lfo_regs: stimulus queues expected events, a negedge monitor checks them.
// Readback checks are compiled in when JT51_LFO_RDBACK_EN is defined.
module tb_jt51_lfo_regs;
   import jt51_lfo_pkg::*;

   localparam int BUSY   = 32;
   localparam int EV_RISE = 0;
   localparam int EV_CFG  = 1;
   localparam int EV_UP   = 2;
   localparam int EV_FALL = 3;

   typedef struct {
      int          kind;
      logic [33:0] val;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       cen;
   logic       cs_n;
   logic       wr_n;
   logic       a0;
   logic [7:0] din;
   logic       busy;
   logic [4:0] cycles;
   logic [7:0] lfo_freq;
   logic [6:0] lfo_amd;
   logic [6:0] lfo_pmd;
   logic [1:0] lfo_w;
   logic [1:0] ct;
   logic [7:0] test;
   logic       lfo_up;
`ifdef JT51_LFO_RDBACK_EN
   logic [7:0] dout;
`endif

   ev_t sbq[$];
   int  tests = 0;
   int  fails = 0;
   int  clkCnt = 0;
   int  tickCnt = 0;
   int  strobeClk = 0;
   int  commitClk = 0;
   int  commitTick = 0;
   int  upRiseClk = 0;

   logic [7:0] mTest, mFreq;
   logic [6:0] mAmd, mPmd;
   logic [1:0] mW, mCt;

   jt51_lfo_regs #(.BUSY_CYC(BUSY), .CYC_RST(5'd0)) dut (
      .clk      (clk),
      .rst      (rst),
      .cen      (cen),
      .cs_n     (cs_n),
      .wr_n     (wr_n),
      .a0       (a0),
      .din      (din),
      .busy     (busy),
      .cycles   (cycles),
      .lfo_freq (lfo_freq),
      .lfo_amd  (lfo_amd),
      .lfo_pmd  (lfo_pmd),
      .lfo_w    (lfo_w),
      .ct       (ct),
      .test     (test),
      .lfo_up   (lfo_up)
`ifdef JT51_LFO_RDBACK_EN
      ,
      .dout     (dout)
`endif
   );

   always #5 clk = ~clk;

   // cen ticks every other clock so gated and ungated behaviour differ.
   initial begin
      cen = 1'b0;
      forever begin
         @(negedge clk);
         cen = ~cen;
      end
   end

   always @(posedge clk) begin
      clkCnt++;
      if (cen) tickCnt++;
   end

   function automatic logic [33:0] cfgPack();
      return {mTest, mFreq, mAmd, mPmd, mW, mCt};
   endfunction

   task automatic checkOutput(input string name, input logic [33:0] act, input logic [33:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic observe(input int kind, input logic [33:0] val);
      ev_t e;
      if (sbq.size() == 0) begin
         tests++;
         fails++;
         $display("[TB] FAIL unexpected_event: got kind %0d value %0h, expected no event", kind, val);
      end else begin
         e = sbq.pop_front();
         checkOutput($sformatf("event%0d_kind", e.kind), 34'(kind), 34'(e.kind));
         checkOutput($sformatf("event%0d_value", e.kind), val, e.val);
      end
   endtask

   // Monitor: turns busy edges, config changes and lfo_up pulses into events for the scoreboard.
   logic        prevRst = 1'b1;
   logic        prevBusy = 1'b0;
   logic        prevUp = 1'b0;
   logic [33:0] prevCfg = '0;
   logic [33:0] cfgNow;

   always @(negedge clk) begin
      cfgNow = {test, lfo_freq, lfo_amd, lfo_pmd, lfo_w, ct};
      if (!rst && !prevRst) begin
         if (busy && !prevBusy) observe(EV_RISE, 34'(clkCnt - strobeClk));
         if (cfgNow != prevCfg) begin
            observe(EV_CFG, cfgNow);
            checkOutput("commit_slot", 34'(cycles), 34'd0);
            commitClk  = clkCnt;
            commitTick = tickCnt;
         end
         if (lfo_up && !prevUp) upRiseClk = clkCnt;
         if (!lfo_up && prevUp)
            observe(EV_UP, 34'(((upRiseClk - commitClk) << 4) | (clkCnt - upRiseClk)));
         if (!busy && prevBusy) observe(EV_FALL, 34'(tickCnt - commitTick));
      end
      prevRst  = rst;
      prevBusy = busy;
      prevUp   = lfo_up;
      prevCfg  = cfgNow;
   end

   task automatic applyStimulus(input logic isData, input logic [7:0] d);
      @(negedge clk);
      cs_n = 1'b0;
      wr_n = 1'b0;
      a0   = isData;
      din  = d;
      strobeClk = clkCnt;
      @(negedge clk);
      cs_n = 1'b1;
      wr_n = 1'b1;
      @(negedge clk);
   endtask

   // Accepted data write: busy rises one clk later, config changes at slot 31,
   // optional lfo_up one clk after the commit, busy falls BUSY ticks after commit.
   task automatic expectData(input bit up);
      sbq.push_back(ev_t'{EV_RISE, 34'd1});
      sbq.push_back(ev_t'{EV_CFG, cfgPack()});
      if (up) sbq.push_back(ev_t'{EV_UP, 34'h11});
      sbq.push_back(ev_t'{EV_FALL, 34'(BUSY)});
   endtask

   task automatic waitDrain(input int maxClk);
      int n = 0;
      while (sbq.size() != 0 && n < maxClk) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (sbq.size() != 0) begin
         fails++;
         $display("[TB] FAIL drain_timeout: %0d events left, expected 0", sbq.size());
         sbq.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int n;
      int t0;
      int wraps;
      int upSeen;
      logic [4:0] prevCyc;

      rst = 1'b1; cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; din = 8'd0;
      {mTest, mFreq, mAmd, mPmd, mW, mCt} = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_cycles", 34'(cycles), 34'd0);
      checkOutput("reset_busy", 34'(busy), 34'd0);
      checkOutput("reset_lfo_up", 34'(lfo_up), 34'd0);
      checkOutput("reset_config", {test, lfo_freq, lfo_amd, lfo_pmd, lfo_w, ct}, 34'd0);

      rst = 1'b0;
      t0 = tickCnt;
      wraps = 0;
      prevCyc = cycles;
      n = 0;
      while ((tickCnt - t0) < 40 && n < 200) begin
         @(negedge clk);
         if (prevCyc == 5'd31 && cycles == 5'd0) wraps++;
         prevCyc = cycles;
         n++;
      end
      checkOutput("cycles_wraps", 34'(wraps), 34'd1);
      checkOutput("cycles_after_40", 34'(cycles), 34'd8);
      checkOutput("idle_busy", 34'(busy), 34'd0);
      checkOutput("idle_config", {test, lfo_freq, lfo_amd, lfo_pmd, lfo_w, ct}, 34'd0);

      $display("[TB] LFRQ write");
      applyStimulus(1'b0, REG_LFRQ);
      mFreq = 8'hA5;
      expectData(1'b1);
      applyStimulus(1'b1, 8'hA5);
      waitDrain(400);

      $display("[TB] PMD then AMD writes, dropped 0x1B write while busy");
      applyStimulus(1'b0, REG_PAMD);
      mPmd = 7'h05;
      expectData(1'b0);
      applyStimulus(1'b1, 8'h85);
      waitDrain(400);
      mAmd = 7'h23;
      expectData(1'b0);
      applyStimulus(1'b1, 8'h23);
      applyStimulus(1'b0, REG_CTW);
      applyStimulus(1'b1, 8'h3C);
      waitDrain(400);
      checkOutput("dropped_lfo_w", 34'(lfo_w), 34'd0);
      checkOutput("dropped_ct", 34'(ct), 34'd0);

      $display("[TB] test register with LFO reset bit");
      applyStimulus(1'b0, REG_TEST);
      mTest = 8'h02;
      expectData(1'b1);
      applyStimulus(1'b1, 8'h02);
      waitDrain(400);

      $display("[TB] reset while LFRQ write pending");
      applyStimulus(1'b0, REG_LFRQ);
      n = 0;
      while (cycles != 5'd2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      sbq.push_back(ev_t'{EV_RISE, 34'd1});
      applyStimulus(1'b1, 8'h77);
      repeat (10) @(negedge clk);
      checkOutput("pending_rise_seen", 34'(sbq.size()), 34'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("midrst_busy", 34'(busy), 34'd0);
      rst = 1'b0;
      {mTest, mFreq, mAmd, mPmd, mW, mCt} = '0;
      upSeen = 0;
      repeat (100) begin
         @(negedge clk);
         if (lfo_up) upSeen++;
      end
      checkOutput("midrst_lfo_up", 34'(upSeen), 34'd0);
      checkOutput("midrst_config", {test, lfo_freq, lfo_amd, lfo_pmd, lfo_w, ct}, cfgPack());
      checkOutput("midrst_busy_after", 34'(busy), 34'd0);

`ifdef JT51_LFO_RDBACK_EN
      $display("[TB] readback");
      applyStimulus(1'b0, REG_LFRQ);
      mFreq = 8'h5A;
      expectData(1'b1);
      applyStimulus(1'b1, 8'h5A);
      cs_n = 1'b0; wr_n = 1'b1; a0 = 1'b0;
      @(negedge clk);
      checkOutput("rd_busy", 34'(dout), 34'h80);
      cs_n = 1'b1;
      waitDrain(400);
      cs_n = 1'b0; wr_n = 1'b1; a0 = 1'b1;
      @(negedge clk);
      checkOutput("rd_lfrq", 34'(dout), 34'h5A);
      cs_n = 1'b1;
      @(negedge clk);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/jt51_lfo_regs.md
Name: jt51_lfo_regs

Overview:
- CPU-side register front end for the LFO stage.
- Accepts YM2151-style address/data bus writes and commits them in a cen-aligned commit window.
- Holds LFO configuration (LFRQ, AMD, PMD, waveform, test) and drives it to the LFO, including the lfo_up reload pulse.
- Generates the free-running 5-bit slot cycle counter that the LFO and the operator pipeline use for timing.

Parameters:
- BUSY_CYC, 32: number of cen ticks busy stays high after an accepted data write (range 2..63).
- CYC_RST, 0: value loaded into cycles on reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cen  in  1  clock enable; all timing below counts cen ticks unless noted.
- cs_n  in  1  chip select, active low.
- wr_n  in  1  write strobe, active low; sampled on clk.
- a0  in  1  0 = address write, 1 = data write.
- din  in  8  bus data.
- busy  out  1  high while a data write is pending or settling.
- cycles  out  5  slot counter, +1 mod 32 per cen.
- lfo_freq  out  8  LFRQ (reg 0x18).
- lfo_amd  out  7  AMD (reg 0x19, din[7]=0).
- lfo_pmd  out  7  PMD (reg 0x19, din[7]=1).
- lfo_w  out  2  waveform (reg 0x1B bits 1:0).
- ct  out  2  control outputs (reg 0x1B bits 7:6).
- test  out  8  test register (reg 0x01).
- lfo_up  out  1  one-clk pulse requesting LFO counter reload.

Behaviour:
- Reset: cycles=CYC_RST; busy=0; lfo_up=0; every register output=0; address latch=0; pending flag=0.
- Bus strobe is a clk-domain edge detect on (cs_n|wr_n) going low. Only one strobe is taken per low phase.
- Address write (a0=0):
  - Always accepted, even while busy.
  - Address latch takes din immediately (next clk).
- Data write (a0=1):
  - When busy=0: capture din and the current address into a pending buffer, then set busy=1 and pending=1 on the next clk.
  - When busy=1: the write is dropped; no register changes.
- Commit:
  - Happens on the first cen tick with cycles==31 while pending=1. Target register updates at that clk edge and pending clears.
  - Decode: 0x01 -> test. 0x18 -> lfo_freq. 0x19 -> din[7] ? lfo_pmd : lfo_amd, taking din[6:0]. 0x1B -> lfo_w=din[1:0], ct=din[7:6].
  - Any other address commits nothing but still runs the busy timer.
- lfo_up:
  - High for exactly one clk, on the clk after a commit to 0x18.
  - Also pulses on a commit to 0x01 with din[1]=1 (LFO reset).
  - Not gated by cen; the LFO latches it until its next cen.
- Busy counter:
  - Loads BUSY_CYC at accept.
  - Decrements on each cen tick only after the commit has happened.
  - busy deasserts on the clk where the counter reaches 0.
  - Minimum busy duration is therefore commit wait (1..32 cen) plus BUSY_CYC cen.
- cen stuck low: cycles holds, pending holds, busy stays high.
- Simultaneous address write and commit: the commit uses the captured address, not the new latch value.
- Reset mid-operation: pending write is discarded, busy drops immediately, no lfo_up is emitted.

Optional Feature:
- Macro: JT51_LFO_RDBACK_EN.
- Defined: adds output dout[7:0]. With cs_n=0, wr_n=1, a0=1, dout is the register for the latched address (0x19 returns {1'b1,pmd} when last 0x19 write had din[7]=1, else {1'b0,amd}). With a0=0, dout={busy,7'd0}. dout is registered with 1 clk latency and reads 0 for unmapped addresses.
- Undefined: no dout port and no read mux; behaviour is otherwise identical.

Decomposition:
- Package jt51_lfo_pkg:
  - register address constants REG_TEST=8'h01, REG_LFRQ=8'h18, REG_PAMD=8'h19, REG_CTW=8'h1B;
  - waveform constants SAWTOOTH/SQUARE/TRIANG/NOISE = 0..3;
  - BUSY_CYC default.
- One natural sub-module: jt51_cyc_cnt, the 5-bit cen-enabled slot counter with reset value, reused by the operator pipeline.

Test Plan:
- Reset, then 40 cen ticks -> cycles wraps 31->0 exactly once; all config outputs 0; busy=0.
- Addr 0x18 then data 0xA5 -> busy=1 next clk; lfo_freq=0xA5 at first cen with cycles==31; lfo_up one-clk pulse one clk later; busy low BUSY_CYC cen after commit.
- Addr 0x19, data 0x85, then after busy clears data 0x23 -> lfo_pmd=0x05, lfo_amd=0x23; no lfo_up for either write.
- Data write 0x3C to 0x1B while busy -> dropped; lfo_w and ct unchanged; busy timing unaffected.
- Data 0x02 to 0x01 -> test=0x02 and lfo_up pulses; assert rst while a 0x18 write is pending -> lfo_freq stays 0, no lfo_up, busy=0.
- With JT51_LFO_RDBACK_EN: write 0x18=0x5A, then read a0=1 -> dout=0x5A after 1 clk; read a0=0 while busy -> dout=0x80.
